pixel_queue_arb: RTL and testbench
==================================

# pixel_queue_arb

Parametrised multi-engine pixel result queue that sits between NUM_ENGINES pixel engines and the frame-buffer writer. Each cycle, a round-robin arbiter accepts at most one finished pixel (colour, x, y) from the engines. Consecutive duplicates from the same engine are dropped. Accepted pixels are stored in a circular FIFO and presented with a valid/ready handshake, tagged with the source engine ID.

## Interface
- DATA_WIDTH, 32, width of the x and y pixel coordinates
- RBG_SIZE, 24, colour width
- NUM_ENGINES, 4, number of engine request channels (≥2)
- ENGINE_BITS, 2, clog2(NUM_ENGINES)
- QUEUE_DEPTH, 16, FIFO entries (power of 2)
- PTR_BITS, 4, clog2(QUEUE_DEPTH)
- AFULL_MARGIN, 2, almost_full asserts when count ≥ QUEUE_DEPTH-AFULL_MARGIN
- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-low reset
- flush_i  in  1  synchronous frame flush
- fin_flag  in  NUM_ENGINES  per-engine request; held until granted
- colour_i  in  NUM_ENGINES*RBG_SIZE  packed colours; engine i occupies slice [i*RBG_SIZE +: RBG_SIZE]
- xpixel_i  in  NUM_ENGINES*DATA_WIDTH  packed x coordinates
- ypixel_i  in  NUM_ENGINES*DATA_WIDTH  packed y coordinates
- grant_o  out  NUM_ENGINES  one-hot or zero, combinational; request consumed this cycle
- valid_o  out  1  head entry available
- ready_i  in  1  consumer takes the head entry when valid_o && ready_i
- colour_o, xpixel_o, ypixel_o  out  RBG_SIZE/DATA_WIDTH/DATA_WIDTH  head entry; all zero when valid_o=0
- engine_id_o  out  ENGINE_BITS  source engine of the head entry; zero when valid_o=0
- count_o  out  PTR_BITS+1  current occupancy
- full_queue  out  1  count_o == QUEUE_DEPTH
- almost_full  out  1  see AFULL_MARGIN
- dup_drop_o  out  1  registered pulse, one cycle after a duplicate is dropped

## Operation
- Reset (async, reset=0): wr_ptr, rd_ptr, count, rr_ptr cleared. All prev_valid[i] cleared. dup_drop_o=0. Consequently valid_o=0, all data outputs 0, grant_o=0, full_queue=0, almost_full=0. FIFO storage is not reset.
- Duplicate test for engine i: dup[i] = prev_valid[i] && xpixel_i[i]==prev_x[i] && ypixel_i[i]==prev_y[i].
- Eligible[i] = fin_flag[i] && (dup[i] || !full_queue) && !flush_i. Duplicates are eligible even when the FIFO is full.
- Arbiter: grant the first eligible engine scanning rr_ptr, rr_ptr+1, … modulo NUM_ENGINES. On a grant to engine k, rr_ptr <= (k+1) mod NUM_ENGINES; with no grant, rr_ptr is held.
- Granted non-duplicate: write {engine k, colour, x, y} at wr_ptr. wr_ptr wraps modulo QUEUE_DEPTH. Set prev_x[k], prev_y[k] and prev_valid[k]=1.
- Granted duplicate: no write, count unchanged, history unchanged. dup_drop_o=1 in the next cycle.
- Pop on valid_o && ready_i: rd_ptr advances with wrap.
- Count: push only → +1; pop only → −1; push and pop in the same cycle → unchanged.
- Full is evaluated on the registered count. A non-duplicate push is blocked while full, even if a pop occurs in the same cycle.
- flush_i: next cycle ptrs, count and all prev_valid are cleared. The flush overrides push and pop in that cycle, and grant_o=0 during it. rr_ptr is kept.

## Timing
- Push-to-visibility latency: 1 cycle. A pixel granted in cycle t gives valid_o=1 with its data in t+1.
- Head data comes from a combinational read of the entry at rd_ptr (show-ahead). The next entry appears in the cycle after a pop.
- grant_o is combinational from fin_flag, the input coordinates and registered state. Engines deassert fin_flag or present a new pixel in the cycle after a grant.
- Sustained throughput: 1 accept and 1 pop per cycle.
- A reset assertion mid-operation discards all contents immediately, without waiting for a clock edge.

## Test plan
- Reset, then engine 0 requests (colour=0xFF0000, x=5, y=7): grant_o=0001. Next cycle valid_o=1, xpixel_o=5, ypixel_o=7, engine_id_o=0, count_o=1.
- All 4 engines hold requests, ready_i=1: grants follow the order 0,1,2,3,0,… Each engine receives 1 grant per 4 cycles.
- Engine 2 presents x=9, y=3 twice in a row: first push → count=1. Second is granted but not stored, count stays 1, dup_drop_o pulses for 1 cycle.
- ready_i=0 and 16 distinct pushes: full_queue=1, almost_full has been 1 since count=14. A 17th non-duplicate request sees grant_o=0. Then ready_i=1 for one cycle → count=15, and the request is granted the following cycle.
- Fill 10 entries, pop 10, push 10 more (wr_ptr wraps): output order matches input order exactly.
- Queue holding 5 entries; assert flush_i for 1 cycle: next cycle count_o=0 and valid_o=0. A previous duplicate is now accepted. Async reset pulse mid-burst: outputs go to 0 immediately.

Source files
------------

// File: rtl/pixel_queue_arb.sv
// rtl/pixel_queue_arb.sv - round-robin pixel accept from several engines into a show-ahead FIFO
// Drops consecutive duplicate coordinates per engine; head entry is tagged with its source engine.
module pixel_queue_arb #(
  parameter int DATA_WIDTH   = 32,
  parameter int RBG_SIZE     = 24,
  parameter int NUM_ENGINES  = 4,
  parameter int ENGINE_BITS  = 2,
  parameter int QUEUE_DEPTH  = 16,
  parameter int PTR_BITS     = 4,
  parameter int AFULL_MARGIN = 2
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              flush_i,
  input  logic [NUM_ENGINES-1:0]            fin_flag,
  input  logic [NUM_ENGINES*RBG_SIZE-1:0]   colour_i,
  input  logic [NUM_ENGINES*DATA_WIDTH-1:0] xpixel_i,
  input  logic [NUM_ENGINES*DATA_WIDTH-1:0] ypixel_i,
  output logic [NUM_ENGINES-1:0]            grant_o,
  output logic                              valid_o,
  input  logic                              ready_i,
  output logic [RBG_SIZE-1:0]               colour_o,
  output logic [DATA_WIDTH-1:0]             xpixel_o,
  output logic [DATA_WIDTH-1:0]             ypixel_o,
  output logic [ENGINE_BITS-1:0]            engine_id_o,
  output logic [PTR_BITS:0]                 count_o,
  output logic                              full_queue,
  output logic                              almost_full,
  output logic                              dup_drop_o
);

  localparam logic [PTR_BITS:0] DEPTH_C = (PTR_BITS+1)'(QUEUE_DEPTH);
  localparam logic [PTR_BITS:0] AFULL_C = (PTR_BITS+1)'(QUEUE_DEPTH - AFULL_MARGIN);

  logic [PTR_BITS-1:0]    wr_ptr, rd_ptr;
  logic [PTR_BITS:0]      count;
  logic [ENGINE_BITS-1:0] rr_ptr;
  logic [NUM_ENGINES-1:0] prev_valid, dup, eligible;
  logic [DATA_WIDTH-1:0]  prev_x [NUM_ENGINES];
  logic [DATA_WIDTH-1:0]  prev_y [NUM_ENGINES];

  logic [RBG_SIZE-1:0]    mem_colour [QUEUE_DEPTH];
  logic [DATA_WIDTH-1:0]  mem_x      [QUEUE_DEPTH];
  logic [DATA_WIDTH-1:0]  mem_y      [QUEUE_DEPTH];
  logic [ENGINE_BITS-1:0] mem_eng    [QUEUE_DEPTH];

  logic                   found, push, pop, drop;
  logic [ENGINE_BITS-1:0] gnt_idx, idx;
  logic [RBG_SIZE-1:0]    sel_colour;
  logic [DATA_WIDTH-1:0]  sel_x, sel_y;

  assign full_queue  = (count == DEPTH_C);
  assign almost_full = (count >= AFULL_C);
  assign valid_o     = (count != '0);
  assign count_o     = count;

  // Duplicates stay eligible when full: they consume the request without needing a slot.
  always_comb begin
    dup      = '0;
    eligible = '0;
    for (int i = 0; i < NUM_ENGINES; i++) begin
      dup[i] = prev_valid[i]
            && (xpixel_i[i*DATA_WIDTH +: DATA_WIDTH] == prev_x[i])
            && (ypixel_i[i*DATA_WIDTH +: DATA_WIDTH] == prev_y[i]);
      eligible[i] = fin_flag[i] && (dup[i] || !full_queue) && !flush_i;
    end
  end

  always_comb begin
    grant_o = '0;
    found   = 1'b0;
    gnt_idx = '0;
    idx     = '0;
    for (int off = 0; off < NUM_ENGINES; off++) begin
      idx = ENGINE_BITS'((int'(rr_ptr) + off) % NUM_ENGINES);
      if (!found && eligible[idx]) begin
        found        = 1'b1;
        gnt_idx      = idx;
        grant_o[idx] = 1'b1;
      end
    end
  end

  assign sel_colour = colour_i[gnt_idx*RBG_SIZE +: RBG_SIZE];
  assign sel_x      = xpixel_i[gnt_idx*DATA_WIDTH +: DATA_WIDTH];
  assign sel_y      = ypixel_i[gnt_idx*DATA_WIDTH +: DATA_WIDTH];

  assign push = found && !dup[gnt_idx];
  assign drop = found &&  dup[gnt_idx];
  assign pop  = valid_o && ready_i;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      rr_ptr     <= '0;
      prev_valid <= '0;
      dup_drop_o <= 1'b0;
    end else if (flush_i) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      prev_valid <= '0;
      dup_drop_o <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr              <= wr_ptr + 1'b1;
        prev_valid[gnt_idx] <= 1'b1;
      end
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)
        count <= count + 1'b1;
      else if (!push && pop)
        count <= count - 1'b1;
      if (found)
        rr_ptr <= ENGINE_BITS'((int'(gnt_idx) + 1) % NUM_ENGINES);
      dup_drop_o <= drop;
    end
  end

  // Storage and coordinate history are qualified by the pointers/prev_valid, so they need no reset.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_colour[wr_ptr] <= sel_colour;
      mem_x[wr_ptr]      <= sel_x;
      mem_y[wr_ptr]      <= sel_y;
      mem_eng[wr_ptr]    <= gnt_idx;
      prev_x[gnt_idx]    <= sel_x;
      prev_y[gnt_idx]    <= sel_y;
    end
  end

  assign colour_o    = valid_o ? mem_colour[rd_ptr] : '0;
  assign xpixel_o    = valid_o ? mem_x[rd_ptr]      : '0;
  assign ypixel_o    = valid_o ? mem_y[rd_ptr]      : '0;
  assign engine_id_o = valid_o ? mem_eng[rd_ptr]    : '0;

endmodule

// File: tb/tb_pixel_queue_arb.sv
// tb/tb_pixel_queue_arb.sv - self-checking bench for pixel_queue_arb
module tb_pixel_queue_arb;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         flush_i = 1'b0;
  logic         ready_i = 1'b0;
  logic [3:0]   fin_flag = '0;
  logic [23:0]  col [4];
  logic [31:0]  xs  [4];
  logic [31:0]  ys  [4];
  logic [95:0]  colour_i;
  logic [127:0] xpixel_i, ypixel_i;
  logic [3:0]   grant_o;
  logic         valid_o, full_queue, almost_full, dup_drop_o;
  logic [23:0]  colour_o;
  logic [31:0]  xpixel_o, ypixel_o;
  logic [1:0]   engine_id_o;
  logic [4:0]   count_o;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      colour_i[i*24 +: 24] = col[i];
      xpixel_i[i*32 +: 32] = xs[i];
      ypixel_i[i*32 +: 32] = ys[i];
    end
  end

  pixel_queue_arb dut (
    .clk(clk), .reset(reset), .flush_i(flush_i), .fin_flag(fin_flag),
    .colour_i(colour_i), .xpixel_i(xpixel_i), .ypixel_i(ypixel_i),
    .grant_o(grant_o), .valid_o(valid_o), .ready_i(ready_i),
    .colour_o(colour_o), .xpixel_o(xpixel_o), .ypixel_o(ypixel_o),
    .engine_id_o(engine_id_o), .count_o(count_o), .full_queue(full_queue),
    .almost_full(almost_full), .dup_drop_o(dup_drop_o)
  );

  // Reference model: a queue of accepted pixels plus per-engine last-accepted coordinates.
  typedef struct { int eng; logic [23:0] c; logic [31:0] x; logic [31:0] y; } ent_t;
  ent_t        mq[$];
  bit          m_pv [4];
  logic [31:0] m_px [4];
  logic [31:0] m_py [4];
  int          m_rr;
  bit          m_dd;

  function automatic bit m_isdup(int k);
    return m_pv[k] && xs[k] == m_px[k] && ys[k] == m_py[k];
  endfunction

  function automatic int m_pick();
    for (int off = 0; off < 4; off++) begin
      int k = (m_rr + off) % 4;
      if (fin_flag[k] && (m_isdup(k) || mq.size() < 16) && !flush_i) return k;
    end
    return -1;
  endfunction

  function automatic logic [102:0] m_vec();
    int g = m_pick();
    logic [3:0] gv = (g >= 0) ? (4'b0001 << g) : 4'b0000;
    ent_t h = '{0, 24'd0, 32'd0, 32'd0};
    int n = mq.size();
    if (n > 0) h = mq[0];
    return {gv, n > 0, h.c, h.x, h.y, 2'(h.eng), 5'(n), n == 16, n >= 14, m_dd};
  endfunction

  task automatic m_reset();
    mq.delete();
    for (int i = 0; i < 4; i++) m_pv[i] = 1'b0;
    m_rr = 0;
    m_dd = 1'b0;
  endtask

  task automatic m_clock();
    int g = m_pick();
    bit d = (g >= 0) && m_isdup(g);
    if (flush_i) begin
      mq.delete();
      for (int i = 0; i < 4; i++) m_pv[i] = 1'b0;
      m_dd = 1'b0;
    end else begin
      if (mq.size() > 0 && ready_i) void'(mq.pop_front());
      if (g >= 0 && !d) begin
        mq.push_back('{g, col[g], xs[g], ys[g]});
        m_pv[g] = 1'b1;
        m_px[g] = xs[g];
        m_py[g] = ys[g];
      end
      m_dd = d;
      if (g >= 0) m_rr = (g + 1) % 4;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    m_clock();
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0; fin_flag = '0; flush_i = 1'b0; ready_i = 1'b0;
    for (int i = 0; i < 4; i++) begin col[i] = '0; xs[i] = '0; ys[i] = '0; end
    m_reset();
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    checks++;
    if ({grant_o, valid_o, count_o, full_queue, almost_full, dup_drop_o, colour_o, xpixel_o, ypixel_o, engine_id_o} !== '0) begin
      failures++;
      $display("FAIL reset_state: got grant=%b valid=%b count=%0d full=%b afull=%b dup=%b, want all 0",
               grant_o, valid_o, count_o, full_queue, almost_full, dup_drop_o);
    end
  endtask

  task automatic test_single();
    do_reset();
    fin_flag = 4'b0001; col[0] = 24'hFF0000; xs[0] = 32'd5; ys[0] = 32'd7;
    #1;
    checks++;
    if (grant_o !== 4'b0001) begin failures++; $display("FAIL single_grant: got %b want 0001", grant_o); end
    tick();
    fin_flag = '0;
    #1;
    checks++;
    if ({valid_o, colour_o, xpixel_o, ypixel_o, engine_id_o, count_o} !== {1'b1, 24'hFF0000, 32'd5, 32'd7, 2'd0, 5'd1}) begin
      failures++;
      $display("FAIL single_head: got valid=%b col=%h x=%0d y=%0d id=%0d count=%0d want 1 ff0000 5 7 0 1",
               valid_o, colour_o, xpixel_o, ypixel_o, engine_id_o, count_o);
    end
  endtask

  task automatic test_round_robin();
    int ng [4] = '{0, 0, 0, 0};
    do_reset();
    ready_i = 1'b1;
    fin_flag = 4'b1111;
    for (int c = 0; c < 12; c++) begin
      for (int i = 0; i < 4; i++) begin
        xs[i] = 32'(c * 16 + i); ys[i] = $urandom; col[i] = 24'($urandom);
      end
      #1;
      for (int i = 0; i < 4; i++) if (grant_o[i]) ng[i]++;
      checks++;
      if (grant_o !== (4'b0001 << (c % 4))) begin
        failures++;
        $display("FAIL rr_order: cycle %0d got %b want %b", c, grant_o, 4'b0001 << (c % 4));
      end
      tick();
    end
    fin_flag = '0;
    checks++;
    if (ng[0] != 3 || ng[1] != 3 || ng[2] != 3 || ng[3] != 3) begin
      failures++;
      $display("FAIL rr_fairness: got %0d %0d %0d %0d want 3 each", ng[0], ng[1], ng[2], ng[3]);
    end
  endtask

  task automatic test_dup();
    do_reset();
    fin_flag = 4'b0100; xs[2] = 32'd9; ys[2] = 32'd3; col[2] = 24'h00AA55;
    #1;
    tick();
    #1;
    checks++;
    if ({count_o, grant_o, dup_drop_o} !== {5'd1, 4'b0100, 1'b0}) begin
      failures++;
      $display("FAIL dup_first: got count=%0d grant=%b dup=%b want 1 0100 0", count_o, grant_o, dup_drop_o);
    end
    tick();
    fin_flag = '0;
    #1;
    checks++;
    if ({count_o, dup_drop_o} !== {5'd1, 1'b1}) begin
      failures++;
      $display("FAIL dup_drop: got count=%0d dup=%b want 1 1", count_o, dup_drop_o);
    end
    tick();
    checks++;
    if (dup_drop_o !== 1'b0) begin failures++; $display("FAIL dup_pulse_end: got %b want 0", dup_drop_o); end
  endtask

  task automatic test_full();
    do_reset();
    fin_flag = 4'b0001;
    for (int i = 0; i < 16; i++) begin
      xs[0] = 32'(100 + i); ys[0] = 32'd1;
      #1;
      checks++;
      if ({grant_o, almost_full, full_queue} !== {4'b0001, i >= 14, 1'b0}) begin
        failures++;
        $display("FAIL fill_%0d: got grant=%b afull=%b full=%b want 0001 %b 0", i, grant_o, almost_full, full_queue, i >= 14);
      end
      tick();
    end
    xs[0] = 32'd500;
    #1;
    checks++;
    if ({count_o, full_queue, almost_full, grant_o} !== {5'd16, 1'b1, 1'b1, 4'b0000}) begin
      failures++;
      $display("FAIL full_block: got count=%0d full=%b afull=%b grant=%b want 16 1 1 0000", count_o, full_queue, almost_full, grant_o);
    end
    ready_i = 1'b1;
    #1;
    checks++;
    if (grant_o !== 4'b0000) begin failures++; $display("FAIL full_pop_block: got %b want 0000", grant_o); end
    tick();
    ready_i = 1'b0;
    #1;
    checks++;
    if ({count_o, full_queue, grant_o} !== {5'd15, 1'b0, 4'b0001}) begin
      failures++;
      $display("FAIL full_release: got count=%0d full=%b grant=%b want 15 0 0001", count_o, full_queue, grant_o);
    end
    tick();
    fin_flag = '0;
    #1;
    checks++;
    if (count_o !== 5'd16) begin failures++; $display("FAIL full_refill: got %0d want 16", count_o); end
  endtask

  task automatic test_wrap();
    ent_t exp[$];
    do_reset();
    for (int pass = 0; pass < 2; pass++) begin
      ready_i = 1'b0;
      fin_flag = 4'b0010;
      for (int i = 0; i < 10; i++) begin
        col[1] = 24'($urandom); xs[1] = {$urandom_range(0, 65535), 16'(pass * 16 + i)}; ys[1] = $urandom;
        exp.push_back('{1, col[1], xs[1], ys[1]});
        tick();
      end
      fin_flag = '0;
      ready_i = 1'b1;
      for (int i = 0; i < 10; i++) begin
        ent_t e = exp.pop_front();
        #1;
        checks++;
        if ({valid_o, colour_o, xpixel_o, ypixel_o, engine_id_o} !== {1'b1, e.c, e.x, e.y, 2'd1}) begin
          failures++;
          $display("FAIL wrap_order p%0d i%0d: got %b %h %h %h %0d want 1 %h %h %h 1",
                   pass, i, valid_o, colour_o, xpixel_o, ypixel_o, engine_id_o, e.c, e.x, e.y);
        end
        tick();
      end
    end
    ready_i = 1'b0;
  endtask

  task automatic test_flush();
    do_reset();
    fin_flag = 4'b1000;
    for (int i = 0; i < 5; i++) begin
      xs[3] = 32'(200 + i); ys[3] = 32'(i); col[3] = 24'h123456;
      tick();
    end
    flush_i = 1'b1;
    #1;
    checks++;
    if ({count_o, grant_o} !== {5'd5, 4'b0000}) begin
      failures++;
      $display("FAIL flush_cycle: got count=%0d grant=%b want 5 0000", count_o, grant_o);
    end
    tick();
    flush_i = 1'b0;
    #1;
    checks++;
    if ({count_o, valid_o, grant_o} !== {5'd0, 1'b0, 4'b1000}) begin
      failures++;
      $display("FAIL flush_after: got count=%0d valid=%b grant=%b want 0 0 1000", count_o, valid_o, grant_o);
    end
    tick();
    fin_flag = '0;
    #1;
    checks++;
    if ({count_o, dup_drop_o, xpixel_o} !== {5'd1, 1'b0, 32'd204}) begin
      failures++;
      $display("FAIL flush_reaccept: got count=%0d dup=%b x=%0d want 1 0 204", count_o, dup_drop_o, xpixel_o);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    fin_flag = 4'b1111;
    for (int c = 0; c < 3; c++) begin
      for (int i = 0; i < 4; i++) begin xs[i] = $urandom; ys[i] = $urandom; col[i] = 24'($urandom); end
      tick();
    end
    fin_flag = '0;
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if ({valid_o, count_o, xpixel_o, colour_o, full_queue, almost_full} !== '0) begin
      failures++;
      $display("FAIL async_reset: got valid=%b count=%0d x=%h col=%h want all 0", valid_o, count_o, xpixel_o, colour_o);
    end
    do_reset();
  endtask

  task automatic test_random();
    logic [102:0] act, exp;
    int bad = 0;
    do_reset();
    for (int c = 0; c < 500; c++) begin
      fin_flag = 4'($urandom);
      ready_i  = ($urandom_range(0, 9) < 6);
      flush_i  = ($urandom_range(0, 49) == 0);
      for (int i = 0; i < 4; i++) begin
        if ($urandom_range(0, 1) == 1) begin
          xs[i] = $urandom_range(0, 3); ys[i] = $urandom_range(0, 1); col[i] = 24'($urandom);
        end
      end
      #1;
      act = {grant_o, valid_o, colour_o, xpixel_o, ypixel_o, engine_id_o, count_o, full_queue, almost_full, dup_drop_o};
      exp = m_vec();
      checks++;
      if (act !== exp) begin
        failures++;
        if (bad < 10) $display("FAIL random cycle %0d: got %h want %h", c, act, exp);
        bad++;
      end
      tick();
    end
    fin_flag = '0; ready_i = 1'b0; flush_i = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_dup();
    test_full();
    test_wrap();
    test_flush();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
